mont_exp_ctrl: RTL and testbench
================================

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  one clock; reset is synchronous and active-low.
REQ-003 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have ports in_x, in_e, in_m, in_r, in_r2  input  512 each  base, exponent, odd modulus, R mod M, R^2 mod M (R=2^512).
REQ-005 SHALL have port result  output  512  x^e mod M.
REQ-006 SHALL have port done  output  1  one-cycle completion pulse.
REQ-007 SHALL have port mul_start  output  1  one-cycle pulse to the Montgomery multiplier.
REQ-008 SHALL have ports mul_a, mul_b, mul_m  output  512 each  multiplier operands.
REQ-009 SHALL have port mul_result  input  512  multiplier product, valid only while mul_done=1.
REQ-010 SHALL have port mul_done  input  1  one-cycle multiplier completion pulse.

Function
REQ-011 SHALL implement left-to-right square-and-multiply: xt=MM(x,R2); A=R; per exponent bit from the MSB 1 down to bit 0: A=MM(A,A), then A=MM(A,xt) if bit=1; finally A=MM(A,1).
REQ-012 SHALL have states IDLE, SKIP, ISSUE, WAIT, FIN, plus a 2-bit op register {PRE, SQR, MUL, POST}.
REQ-013 IDLE: start=1 SHALL latch x, e, M, R, R2 into internal registers, set A=R, set cnt=512, set op=PRE, and go to ISSUE.
REQ-014 ISSUE SHALL assert mul_start for exactly one cycle, then go to WAIT.
REQ-015 Operands SHALL be PRE:(x,R2), SQR:(A,A), MUL:(A,xt), POST:(A,1); mul_m=M.
REQ-016 Operands SHALL stay stable from the ISSUE cycle until and including the mul_done cycle.
REQ-017 WAIT SHALL ignore mul_result until mul_done=1; on mul_done, PRE writes xt and goes to SKIP; SQR/MUL/POST write A.
REQ-018 SKIP SHALL process one exponent position per cycle:
- cnt=0 -> op=POST, go to ISSUE.
- E[511]=1 -> op=SQR, go to ISSUE.
- Otherwise shift E left 1, decrement cnt, stay in SKIP.
REQ-019 After SQR completes:
- E[511]=1 -> op=MUL, go to ISSUE.
- Otherwise advance.
REQ-020 After MUL completes, the FSM SHALL advance.
REQ-021 Advance SHALL shift E left 1 and decrement cnt; if the new cnt=0 -> op=POST, else op=SQR; go to ISSUE.
REQ-022 After POST completes, the FSM SHALL go to FIN.
REQ-023 FIN SHALL assert done for exactly one cycle, copy A to result, and return to IDLE.
REQ-024 result SHALL hold its value until the next FIN or reset.
REQ-025 Latency SHALL be exactly 1 cycle from mul_done to the next mul_start, and exactly 1 cycle from the POST mul_done to done.
REQ-026 start asserted outside IDLE SHALL be ignored, with no effect on state or operands.
REQ-027 A mul_done received outside WAIT SHALL be ignored.
REQ-028 e=0 SHALL issue exactly PRE and POST and produce result=1; e with k set bits and MSB position p SHALL issue exactly 2+(p+1)+k multiplications.
REQ-029 cnt SHALL be 10 bits; the MSB scan SHALL never wrap below 0.

Reset
REQ-030 While resetn=0 at a clock edge, the block SHALL enter IDLE and drive result=0, done=0, mul_start=0, mul_a=mul_b=mul_m=0, and clear all internal registers.
REQ-031 Reset in any state, including mid-WAIT, SHALL abort the operation with no done pulse; a later mul_done for the aborted operation SHALL be ignored per REQ-027.

Verification
REQ-032 The bench SHALL use a behavioural MM model with programmable latency and cover these scenarios:
- x=5, e=0, M=13 -> 2 mul_start pulses (PRE, POST); result=1; done pulses once.
- x=5, e=1, M=13 -> 4 pulses (PRE, SQR, MUL, POST); result=5.
- x=2, e=3, M=7 -> 6 pulses; result=1; SKIP occupies 510 cycles.
- x=3, e=2^511, M=2^511+... random odd 512-bit -> 515 pulses; result matches the golden model.
- MM latency 1 vs 700 cycles with random 512-bit x, e, M -> identical results; start pulsed mid-run -> ignored.
- resetn=0 mid-WAIT, with mul_done arriving afterwards -> outputs 0, no done pulse; the next start with x=5, e=1, M=13 -> result=5.

Source files
------------

// File: rtl/mont_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mont_exp_ctrl_if
//  Description : Bundle of the request/result bus and the Montgomery
//                multiplier handshake used by mont_exp_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
interface mont_exp_ctrl_if #(
   parameter int WIDTH = 512
);
   // request side
   logic             start;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_e;
   logic [WIDTH-1:0] in_m;
   logic [WIDTH-1:0] in_r;
   logic [WIDTH-1:0] in_r2;
   logic [WIDTH-1:0] result;
   logic             done;
   // multiplier side
   logic             mul_start;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_m;
   logic [WIDTH-1:0] mul_result;
   logic             mul_done;

   // Controller view
   modport slave (
      input  start, in_x, in_e, in_m, in_r, in_r2, mul_result, mul_done,
      output result, done, mul_start, mul_a, mul_b, mul_m
   );

   // Environment view (requester plus multiplier)
   modport master (
      output start, in_x, in_e, in_m, in_r, in_r2, mul_result, mul_done,
      input  result, done, mul_start, mul_a, mul_b, mul_m
   );
endinterface
`default_nettype wire

// File: rtl/mont_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mont_exp_ctrl
//  Description : Sequencer for 512-bit Montgomery modular exponentiation using
//                left-to-right square-and-multiply around an external
//                Montgomery multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
module mont_exp_ctrl (
   input  wire logic           clk,
   input  wire logic           resetn,
   mont_exp_ctrl_if.slave      bus
);

   localparam int W     = 512;
   localparam int CNT_W = 10;

   localparam logic [CNT_W-1:0] CNT_FULL = 10'd512;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SKIP  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_PRE  = 2'd0,
      OP_SQR  = 2'd1,
      OP_MUL  = 2'd2,
      OP_POST = 2'd3
   } op_t;

   state_t           state_q,     state_d;
   op_t              op_q,        op_d;
   logic [W-1:0]     e_q,         e_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [W-1:0]     a_q,         a_d;
   logic [W-1:0]     xt_q,        xt_d;
   logic [W-1:0]     result_q,    result_d;
   logic             done_q,      done_d;
   logic             mul_start_q, mul_start_d;
   logic [W-1:0]     mul_a_q,     mul_a_d;
   logic [W-1:0]     mul_b_q,     mul_b_d;
   logic [W-1:0]     mul_m_q,     mul_m_d;

   // helpers for launching the next multiplication
   logic             issue_en;
   op_t              issue_op;
   logic [W-1:0]     issue_acc;
   logic             advance;

   // Next-state and operand selection for the exponentiation sequencer
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      e_d         = e_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      xt_d        = xt_q;
      result_d    = result_q;
      done_d      = 1'b0;
      mul_start_d = 1'b0;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_m_d     = mul_m_q;
      issue_en    = 1'b0;
      issue_op    = OP_SQR;
      issue_acc   = a_q;
      advance     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               // operand registers double as the latched x, R2 and M
               e_d         = bus.in_e;
               a_d         = bus.in_r;
               cnt_d       = CNT_FULL;
               op_d        = OP_PRE;
               mul_a_d     = bus.in_x;
               mul_b_d     = bus.in_r2;
               mul_m_d     = bus.in_m;
               mul_start_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (bus.mul_done) begin
               case (op_q)
                  OP_PRE: begin
                     xt_d    = bus.mul_result;
                     state_d = S_SKIP;
                  end
                  OP_SQR: begin
                     a_d = bus.mul_result;
                     if (e_q[W-1]) begin
                        issue_en  = 1'b1;
                        issue_op  = OP_MUL;
                        issue_acc = bus.mul_result;
                     end else begin
                        advance = 1'b1;
                     end
                  end
                  OP_MUL: begin
                     a_d     = bus.mul_result;
                     advance = 1'b1;
                  end
                  default: begin
                     a_d      = bus.mul_result;
                     result_d = bus.mul_result;
                     done_d   = 1'b1;
                     state_d  = S_FIN;
                  end
               endcase
            end
         end

         S_SKIP: begin
            // cnt is checked before any decrement so the scan stops at zero
            if (cnt_q == '0) begin
               issue_en = 1'b1;
               issue_op = OP_POST;
            end else if (e_q[W-1]) begin
               issue_en = 1'b1;
               issue_op = OP_SQR;
            end else begin
               e_d   = {e_q[W-2:0], 1'b0};
               cnt_d = cnt_q - 10'd1;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // move to the next exponent bit after a finished square or multiply
      if (advance) begin
         e_d       = {e_q[W-2:0], 1'b0};
         cnt_d     = cnt_q - 10'd1;
         issue_en  = 1'b1;
         issue_acc = bus.mul_result;
         issue_op  = (cnt_q == 10'd1) ? OP_POST : OP_SQR;
      end

      // launch: operands are loaded here and then left untouched until mul_done
      if (issue_en) begin
         op_d        = issue_op;
         state_d     = S_ISSUE;
         mul_start_d = 1'b1;
         mul_a_d     = issue_acc;
         case (issue_op)
            OP_SQR:  mul_b_d = issue_acc;
            OP_MUL:  mul_b_d = xt_q;
            OP_POST: mul_b_d = {{(W-1){1'b0}}, 1'b1};
            default: mul_b_d = mul_b_q;
         endcase
      end
   end

   // State, datapath and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         op_q        <= OP_PRE;
         e_q         <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         xt_q        <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_m_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         e_q         <= e_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         xt_q        <= xt_d;
         result_q    <= result_d;
         done_q      <= done_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_m_q     <= mul_m_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.done      = done_q;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.mul_m     = mul_m_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mont_exp_ctrl
//  Description : Self-checking bench for mont_exp_ctrl with a behavioural
//                Montgomery multiplier of programmable latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mont_exp_ctrl;

   localparam int W    = 512;
   localparam int HMAX = 1200;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   mont_exp_ctrl_if bus ();

   mont_exp_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // multiplier model and monitor state
   int           mm_lat    = 1;
   int           mm_cnt    = 0;
   logic         mm_track  = 1'b0;
   logic [W-1:0] mm_a, mm_b, mm_m, mm_res;
   int           cyc       = 0;
   int           pulse_cnt = 0;
   int           dn_idx    = 0;
   int           done_cnt  = 0;
   int           done_cyc  = 0;
   logic [W-1:0] done_res  = '0;
   int           stab_err  = 0;
   int           proto_err = 0;
   logic         prev_start = 1'b0;
   int           st_cyc [0:HMAX-1];
   int           dn_cyc [0:HMAX-1];

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] e;
      logic [W-1:0] m;
      int           lat;
      logic [W-1:0] exp_res;
      int           exp_ops;
   } vec_t;

   task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rand512();
      logic [W-1:0] v;
      for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // a*b*2^-512 mod m, bit-serial REDC (b < m)
   function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
      logic [W+1:0] t;
      t = '0;
      for (int i = 0; i < W; i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, m};
         t = t >> 1;
      end
      if (t >= {2'b00, m}) t = t - {2'b00, m};
      return t[W-1:0];
   endfunction

   // golden x^e mod m with plain modular arithmetic
   function automatic logic [W-1:0] mod_exp(input logic [W-1:0] x, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
      logic [2*W-1:0] r, b, mm;
      mm = {{W{1'b0}}, m};
      r  = 1;
      b  = {{W{1'b0}}, x} % mm;
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * b) % mm;
         b = (b * b) % mm;
      end
      return r[W-1:0];
   endfunction

   function automatic int exp_ops(input logic [W-1:0] e);
      int p = -1;
      int k = 0;
      for (int i = 0; i < W; i++) begin
         if (e[i]) begin
            k++;
            p = i;
         end
      end
      if (p < 0) return 2;
      return 2 + (p + 1) + k;
   endfunction

   function automatic logic [W-1:0] r_mod(input logic [W-1:0] m);
      logic [2*W-1:0] t;
      t = ({{(2*W-1){1'b0}}, 1'b1} << W) % {{W{1'b0}}, m};
      return t[W-1:0];
   endfunction

   function automatic logic [W-1:0] r2_mod(input logic [W-1:0] m);
      logic [2*W-1:0] t;
      logic [W-1:0]   r;
      r = r_mod(m);
      t = ({{W{1'b0}}, r} * {{W{1'b0}}, r}) % {{W{1'b0}}, m};
      return t[W-1:0];
   endfunction

   // behavioural multiplier plus output monitor, sampled 1 time unit after the edge
   initial begin
      bus.mul_done   = 1'b0;
      bus.mul_result = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         bus.mul_done   = 1'b0;
         bus.mul_result = rand512();
         if (!resetn) mm_track = 1'b0;
         if (mm_cnt > 0) begin
            if (mm_track && resetn &&
                (bus.mul_a !== mm_a || bus.mul_b !== mm_b || bus.mul_m !== mm_m))
               stab_err++;
            mm_cnt--;
            if (mm_cnt == 0) begin
               bus.mul_done   = 1'b1;
               bus.mul_result = mm_res;
               if (dn_idx < HMAX) dn_cyc[dn_idx] = cyc;
               dn_idx++;
            end
         end
         if (bus.mul_start) begin
            if (mm_cnt != 0 || prev_start) proto_err++;
            if (pulse_cnt < HMAX) st_cyc[pulse_cnt] = cyc;
            pulse_cnt++;
            mm_a     = bus.mul_a;
            mm_b     = bus.mul_b;
            mm_m     = bus.mul_m;
            mm_res   = mont_mul(mm_a, mm_b, mm_m);
            mm_cnt   = mm_lat;
            mm_track = 1'b1;
         end
         prev_start = bus.mul_start;
         if (bus.done) begin
            done_cnt++;
            done_res = bus.result;
            done_cyc = cyc;
         end
      end
   end

   task automatic drive_req(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] m);
      bus.in_x  = x;
      bus.in_e  = e;
      bus.in_m  = m;
      bus.in_r  = r_mod(m);
      bus.in_r2 = r2_mod(m);
   endtask

   task automatic scramble_req();
      bus.in_x  = rand512();
      bus.in_e  = rand512();
      bus.in_m  = rand512();
      bus.in_r  = rand512();
      bus.in_r2 = rand512();
   endtask

   // one complete exponentiation; poke_at>0 pulses a stray start on that cycle
   task automatic run_exp(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] m,
                          input int lat, input int poke_at,
                          output logic [W-1:0] res, output int pulses, output int dones,
                          output int lat_err, output int skip_gap);
      int cycles;
      int budget;
      mm_lat    = lat;
      pulse_cnt = 0;
      dn_idx    = 0;
      done_cnt  = 0;
      budget    = 1030 * (lat + 3) + 1200;
      @(posedge clk);
      #1;
      drive_req(x, e, m);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      scramble_req();
      cycles = 0;
      while (done_cnt == 0 && cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
         if (poke_at > 0 && cycles == poke_at) begin
            scramble_req();
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      if (done_cnt == 0) $display("FAIL run_timeout: got no done after %0d cycles, required done", cycles);
      repeat (4) @(posedge clk);
      #1;
      res     = done_res;
      pulses  = pulse_cnt;
      dones   = done_cnt;
      lat_err = 0;
      for (int i = 1; i + 1 < pulses && i + 1 < HMAX; i++)
         if (st_cyc[i+1] - dn_cyc[i] != 1) lat_err++;
      if (pulses >= 1 && pulses <= HMAX && done_cyc - dn_cyc[pulses-1] != 1) lat_err++;
      skip_gap = (pulses >= 2) ? st_cyc[1] - dn_cyc[0] : -1;
   endtask

   task automatic check_idle_zero(input string tag);
      check_vec({tag, "_result"}, bus.result, '0);
      check_int({tag, "_done"}, int'(bus.done), 0);
      check_int({tag, "_mul_start"}, int'(bus.mul_start), 0);
      check_vec({tag, "_mul_a"}, bus.mul_a, '0);
      check_vec({tag, "_mul_b"}, bus.mul_b, '0);
      check_vec({tag, "_mul_m"}, bus.mul_m, '0);
   endtask

   initial begin
      vec_t         vecs [6];
      logic [W-1:0] res, res1, x, e, m, gold;
      int           pulses, dones, lat_err, gap, perr0, serr0;

      bus.start = 1'b0;
      drive_req(512'd5, 512'd0, 512'd13);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      resetn = 1'b1;

      vecs[0] = '{x: 512'd5, e: 512'd0,  m: 512'd13, lat: 1, exp_res: 512'd1, exp_ops: 2};
      vecs[1] = '{x: 512'd5, e: 512'd1,  m: 512'd13, lat: 1, exp_res: 512'd5, exp_ops: 4};
      vecs[2] = '{x: 512'd2, e: 512'd3,  m: 512'd7,  lat: 2, exp_res: 512'd1, exp_ops: 6};
      vecs[3] = '{x: 512'd3, e: 512'd5,  m: 512'd7,  lat: 1, exp_res: 512'd5, exp_ops: 7};
      vecs[4] = '{x: 512'd7, e: 512'd10, m: 512'd11, lat: 3, exp_res: 512'd1, exp_ops: 8};
      vecs[5] = '{x: 512'd5, e: 512'd1,  m: 512'd13, lat: 5, exp_res: 512'd5, exp_ops: 4};

      for (int i = 0; i < 6; i++) begin
         perr0 = proto_err;
         serr0 = stab_err;
         run_exp(vecs[i].x, vecs[i].e, vecs[i].m, vecs[i].lat, 0, res, pulses, dones, lat_err, gap);
         check_vec($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
         check_int($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_ops);
         check_int($sformatf("vec%0d_done_pulses", i), dones, 1);
         check_int($sformatf("vec%0d_latency", i), lat_err, 0);
         check_int($sformatf("vec%0d_protocol", i), proto_err - perr0, 0);
         check_int($sformatf("vec%0d_stability", i), stab_err - serr0, 0);
         check_vec($sformatf("vec%0d_result_hold", i), bus.result, vecs[i].exp_res);
         if (i == 2) check_int("e3_skip_gap", gap, 512);
      end

      // only the top exponent bit set: full-length square chain
      m = rand512();
      m[W-1] = 1'b1;
      m[0]   = 1'b1;
      e = '0;
      e[W-1] = 1'b1;
      run_exp(512'd3, e, m, 1, 0, res, pulses, dones, lat_err, gap);
      check_vec("msb_result", res, mod_exp(512'd3, e, m));
      check_int("msb_pulses", pulses, 515);
      check_int("msb_skip_gap", gap, 2);
      check_int("msb_latency", lat_err, 0);

      // random full-width operands
      for (int r = 0; r < 3; r++) begin
         x = rand512();
         e = rand512();
         m = rand512();
         m[0] = 1'b1;
         m[W-1] = 1'b1;
         run_exp(x, e, m, int'($urandom_range(1, 3)), 0, res, pulses, dones, lat_err, gap);
         check_vec($sformatf("rand%0d_result", r), res, mod_exp(x, e, m));
         check_int($sformatf("rand%0d_pulses", r), pulses, exp_ops(e));
         check_int($sformatf("rand%0d_done_pulses", r), dones, 1);
         check_int($sformatf("rand%0d_latency", r), lat_err, 0);
      end

      // short and long multiplier latency on the same operands, stray start in the long run
      x = rand512();
      m = rand512();
      m[0] = 1'b1;
      m[W-1] = 1'b1;
      e = '0;
      e[19:0] = 20'($urandom);
      e[19] = 1'b1;
      gold = mod_exp(x, e, m);
      run_exp(x, e, m, 1, 0, res1, pulses, dones, lat_err, gap);
      check_vec("lat1_result", res1, gold);
      perr0 = proto_err;
      serr0 = stab_err;
      run_exp(x, e, m, 700, 1500, res, pulses, dones, lat_err, gap);
      check_vec("lat700_result", res, gold);
      check_int("lat700_pulses", pulses, exp_ops(e));
      check_int("lat700_done_pulses", dones, 1);
      check_int("lat700_latency", lat_err, 0);
      check_int("lat700_stability", stab_err - serr0, 0);
      check_int("lat700_protocol", proto_err - perr0, 0);

      // reset while waiting on the multiplier, late mul_done must be ignored
      mm_lat    = 40;
      pulse_cnt = 0;
      done_cnt  = 0;
      @(posedge clk);
      #1;
      drive_req(512'd5, 512'd1, 512'd13);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_int("abort_pre_pulses", pulse_cnt, 1);
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("abort_in_reset");
      resetn = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check_int("abort_no_done", done_cnt, 0);
      check_int("abort_no_new_pulse", pulse_cnt, 1);
      check_idle_zero("abort_after");

      run_exp(512'd5, 512'd1, 512'd13, 1, 0, res, pulses, dones, lat_err, gap);
      check_vec("post_abort_result", res, 512'd5);
      check_int("post_abort_pulses", pulses, 4);
      check_int("post_abort_done_pulses", dones, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
